// File: rtl/data_mem_lsu.sv
// Word-organised data memory with load/store unit: byte/half/word access, extension, error checks.
// Latency: request accepted in cycle N, response valid from cycle N+2; one request in flight.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready handshake.
module data_mem_lsu #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WIDX_W = ADDR_WIDTH - 2;

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("data_mem_lsu: DATA_WIDTH must be 32");
        end
        if (DEPTH < 2 || DEPTH > (2 ** WIDX_W)) begin : g_bad_depth
            $error("data_mem_lsu: DEPTH out of range for ADDR_WIDTH");
        end
    endgenerate

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  lat_write;
    logic [1:0]            lat_size;
    logic                  lat_signed;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [WIDX_W-1:0]     word_idx;
    logic [IDX_W-1:0]      mem_idx;
    logic [1:0]            lane;
    logic                  idx_oob;
    logic                  access_err;
    logic                  mem_we;
    logic [3:0]            wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;

    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_error_q;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gate with rst_n so the block never advertises readiness while held in reset.
    assign req_ready  = (state_q == IDLE) && rst_n;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

    // ---------------- request capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_write  <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (state_q == IDLE && req_valid) begin
            lat_write  <= req_write;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
        end
    end

    // ---------------- address decode and error check ----------------
    assign word_idx = lat_addr[ADDR_WIDTH-1:2];
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign lane     = lat_addr[1:0];
    // Extra bit so DEPTH == 2**WIDX_W does not truncate to zero.
    assign idx_oob  = {1'b0, word_idx} >= (WIDX_W + 1)'(DEPTH);

    always_comb begin
        access_err = idx_oob;
        case (lat_size)
            SZ_BYTE: ;
            SZ_HALF: if (lat_addr[0]) access_err = 1'b1;
            SZ_WORD: if (lane != 2'b00) access_err = 1'b1;
            default: access_err = 1'b1;
        endcase
    end

    // ---------------- store path ----------------
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = lat_wdata;
        case (lat_size)
            SZ_BYTE: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{lat_wdata[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = lat_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{lat_wdata[15:0]}};
            end
            SZ_WORD: wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    assign mem_we = (state_q == ACCESS) && lat_write && !access_err;

    // Array is deliberately not reset; rst_n only suppresses an in-flight write.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[mem_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    // ---------------- load path ----------------
    assign rd_word = mem[mem_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = '0;
        case (lat_size)
            SZ_BYTE: load_data = {{24{lat_signed & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_data = {{16{lat_signed & rd_half[15]}}, rd_half};
            SZ_WORD: load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    // ---------------- response registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else if (state_q == ACCESS) begin
            resp_error_q <= access_err;
            resp_rdata_q <= (!lat_write && !access_err) ? load_data : '0;
        end else if (state_q == RESP && resp_ready) begin
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu: stores/loads of all sizes, errors,
// response backpressure, back-to-back acceptance and reset during ACCESS.
module tb_data_mem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int checks;
    int failures;

    data_mem_lsu #(.ADDR_WIDTH(16), .DEPTH(1024), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full request/response; returns response fields and edges from accept cycle to resp_valid.
    task automatic xact(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [15:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
        int n;
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            lat++;
        end while (!resp_valid && lat < 20);
        rd = resp_rdata;
        e  = resp_error;
        if (!resp_valid) begin
            checks++;
            failures++;
            $display("FAIL xact_timeout addr=%h: resp_valid=%b, required 1", a, resp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, required 0 0 00000000 0",
                     req_ready, resp_valid, resp_rdata, resp_error);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; int lat;
        xact(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, rd, e, lat);
        checks++;
        if (rd !== 32'h0 || e !== 1'b0 || lat != 2) begin
            failures++;
            $display("FAIL store_word: rdata=%h err=%b lat=%0d, required 00000000 0 2", rd, e, lat);
        end
        xact(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0 || lat != 2) begin
            failures++;
            $display("FAIL load_word: rdata=%h err=%b lat=%0d, required deadbeef 0 2", rd, e, lat);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic e; int lat;
        xact(1'b1, 2'b10, 1'b0, 16'h0000, 32'h0, rd, e, lat);
        xact(1'b1, 2'b00, 1'b0, 16'h0000, 32'h123456FF, rd, e, lat);
        xact(1'b0, 2'b00, 1'b1, 16'h0000, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFFFFFF || e !== 1'b0) begin
            failures++;
            $display("FAIL load_byte_signed: rdata=%h err=%b, required ffffffff 0", rd, e);
        end
        xact(1'b0, 2'b00, 1'b0, 16'h0000, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h000000FF) begin
            failures++;
            $display("FAIL load_byte_unsigned: rdata=%h, required 000000ff", rd);
        end
        xact(1'b0, 2'b10, 1'b0, 16'h0000, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h000000FF) begin
            failures++;
            $display("FAIL byte_lane_isolation: rdata=%h, required 000000ff", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        xact(1'b1, 2'b01, 1'b0, 16'h0013, 32'h00008001, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL misaligned_half_store: err=%b rdata=%h, required 1 00000000", e, rd);
        end
        xact(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            failures++;
            $display("FAIL no_write_on_error: rdata=%h err=%b, required deadbeef 0", rd, e);
        end
        xact(1'b0, 2'b10, 1'b0, 16'h1000, 32'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL out_of_range: err=%b rdata=%h, required 1 00000000", e, rd);
        end
        xact(1'b0, 2'b11, 1'b0, 16'h0000, 32'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL illegal_size: err=%b rdata=%h, required 1 00000000", e, rd);
        end
        xact(1'b0, 2'b10, 1'b0, 16'h0002, 32'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_word: err=%b, required 1", e);
        end
        xact(1'b1, 2'b10, 1'b0, 16'h0FFC, 32'h0BADF00D, rd, e, lat);
        xact(1'b0, 2'b10, 1'b0, 16'h0FFC, 32'h0, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL last_word: err=%b rdata=%h, required 0 0badf00d", e, rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic e; int lat;
        xact(1'b1, 2'b01, 1'b0, 16'h0012, 32'hAAAA8001, rd, e, lat);
        xact(1'b0, 2'b01, 1'b1, 16'h0012, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFF8001 || e !== 1'b0) begin
            failures++;
            $display("FAIL load_half_signed: rdata=%h err=%b, required ffff8001 0", rd, e);
        end
        xact(1'b0, 2'b01, 1'b0, 16'h0012, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h00008001) begin
            failures++;
            $display("FAIL load_half_unsigned: rdata=%h, required 00008001", rd);
        end
        xact(1'b0, 2'b00, 1'b1, 16'h0011, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFFFFBE) begin
            failures++;
            $display("FAIL load_byte_lane1: rdata=%h, required ffffffbe", rd);
        end
        xact(1'b0, 2'b10, 1'b1, 16'h0010, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h8001BEEF) begin
            failures++;
            $display("FAIL half_merge_word: rdata=%h, required 8001beef", rd);
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 16'h0010; req_wdata = '0; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_size = 2'b00; req_addr = 16'h0010;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h8001BEEF || resp_error !== 1'b0 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL resp_hold cycle %0d: valid=%b rdata=%h err=%b ready=%b, required 1 8001beef 0 0",
                         i, resp_valid, resp_rdata, resp_error, req_ready);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_handshake: valid=%b ready=%b, required 0 1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000EF || resp_error !== 1'b0) begin
            failures++;
            $display("FAIL pending_request: valid=%b rdata=%h err=%b, required 1 000000ef 0",
                     resp_valid, resp_rdata, resp_error);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_access();
        logic [31:0] rd; logic e; int lat;
        xact(1'b1, 2'b10, 1'b0, 16'h0020, 32'hA5A5A5A5, rd, e, lat);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 16'h0020; req_wdata = 32'h12345678; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_access: valid=%b ready=%b rdata=%h err=%b, required 0 0 00000000 0",
                     resp_valid, req_ready, resp_rdata, resp_error);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xact(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hA5A5A5A5 || e !== 1'b0) begin
            failures++;
            $display("FAIL aborted_store: rdata=%h err=%b, required a5a5a5a5 0", rd, e);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_word();
        test_byte();
        test_errors();
        test_half();
        test_back_to_back();
        test_reset_in_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
